floating_addition: RTL and testbench
====================================

# floating_addition

Single-precision (IEEE 754 binary32) floating-point adder with a registered output. It sits in the floating-point ALU as the add/subtract datapath. The adder sign-aligns, adds or subtracts the significands, normalizes and rounds in one combinational stage. The result is captured into an output register on an enabled clock edge.

## Interface
- No parameters; the width is fixed at 32 bits.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- EN  input  1  load enable for the output register.
- A  input  32  operand A, binary32 (sign [31], exponent [30:23], fraction [22:0]).
- B  input  32  operand B, binary32.
- OUT_Add  output  32  registered result, A + B, binary32.

## Operation
- Special cases are checked first, in this priority order:
  - Either operand is NaN (exp=FF, frac≠0) → 0x7FC00000 (canonical quiet NaN).
  - +inf plus -inf → 0x7FC00000.
  - One or both operands are inf → that inf, with its sign.
  - Either operand is zero or subnormal (exp=00) → treat it as signed zero. The result is the other operand unchanged. -0 + -0 → 0x80000000; +0 + -0 → 0x00000000.
- General case:
  - Build 24-bit significands with the hidden 1.
  - The larger-magnitude operand is the one with larger {exp, frac}. Shift the smaller significand right by the exponent difference.
  - Keep guard, round and sticky bits; all bits shifted out past the round position OR into sticky. A difference >26 leaves only sticky.
- Equal signs → add. A carry-out shifts right by 1 and increments the exponent.
- Opposite signs → subtract the smaller from the larger. The sign comes from the larger operand. Left-normalize with a leading-zero count and decrement the exponent.
- Exact cancellation (x + -x) → +0 (0x00000000).
- Rounding is round-to-nearest-even. A rounding carry renormalizes (significand 0x1000000 → shift right, exponent +1).
- Result exponent ≥ FF → signed inf (exp=FF, frac=0).
- Result exponent ≤ 0 → flush to signed zero. Subnormals are never produced.

## Timing
- OUT_Add is a register. Its reset value is 0x00000000.
- On each rising CLK edge, in priority order:
  - RST=1 → OUT_Add ← 0. This overrides EN.
  - Else EN=1 → OUT_Add ← f(A, B), computed from the A and B present at that edge.
  - Else OUT_Add holds.
- Latency is 1 cycle: the result is visible after the first enabled edge following operand setup.
- There is no pipeline and no handshake. A new operand pair can be accepted every cycle.
- Asserting reset mid-stream clears the output on that edge. The first result after RST drops appears on the first edge with EN=1.
- Changing operands while EN=0 has no effect on OUT_Add.

## Test plan
- RST=1 for 2 cycles with any A/B and EN=1 → OUT_Add=0x00000000. Then RST=0, EN=1, A=0x41B26666 (22.3), B=0xBF000000 (-0.5) → after one edge, 0x41AE6666 (21.8).
- Rounding, EN=1:
  - 0x417CCCCD (15.8) + 0x3FA66666 (1.3) → 0x4188CCCD.
  - 0x3F28F5C2 (0.66) + 0x3F028F5C (0.51) → 0x3F95C28F.
- Signs and zero, EN=1:
  - 0xC0CCCCCC (-6.4) + 0xBF000000 (-0.5) → 0xC0DCCCCC.
  - 0x40CCCCCC + 0xBF000000 → 0x40BCCCCC, and with operands swapped → 0x40BCCCCC.
  - 0xBF800000 (-1) + 0x40000000 (2) → 0x3F800000.
  - 0x42600000 (56) + 0x00000000 → 0x42600000.
- Specials:
  - 0xFF800000 (-inf) + 0x404CCCCC → 0xFF800000.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - 0x3F800000 + 0xBF800000 → 0x00000000.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
- Enable/hold: load 0x3F800000 + 0x3F800000 (→ 0x40000000), then EN=0 and change the operands for 3 cycles → OUT_Add stays 0x40000000. EN=1 → updates on the next edge.

Source files
------------

// File: rtl/floating_addition.sv
// ---------------------------------------------------------------------------
// floating_addition
// IEEE 754 binary32 adder with a registered result. Special operands,
// alignment, add/subtract, normalization and round-to-nearest-even are all
// resolved combinationally; the packed result is captured on an enabled edge.
// Subnormal operands are read as signed zero and subnormal results flush
// to signed zero.
//
// Ports:
//   CLK     in   1   clock, rising edge
//   RST     in   1   synchronous active-high reset, clears OUT_Add
//   EN      in   1   load enable for OUT_Add
//   A       in  32   operand A (binary32)
//   B       in  32   operand B (binary32)
//   OUT_Add out 32   registered A + B (binary32)
// ---------------------------------------------------------------------------
module floating_addition (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] OUT_Add
);

    localparam logic [31:0] QNAN = 32'h7FC00000;

    // Leading-zero count of a 27-bit working significand.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       done;
        n    = 5'd0;
        done = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n    = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Round-to-nearest-even on a normalized {1.f[22:0], G, R, S} significand,
    // then pack with overflow to inf and underflow flush to signed zero.
    function automatic logic [31:0] round_pack(input logic              s,
                                               input logic signed [9:0] e,
                                               input logic [26:0]       m);
        logic [24:0]       rm;
        logic              up;
        logic signed [9:0] ef;
        logic [22:0]       fr;
        up = m[2] & (m[1] | m[0] | m[3]);
        rm = {1'b0, m[26:3]} + {24'd0, up};
        // Rounding carry turns 1.111..1 into 10.000..0: renormalize.
        if (rm[24]) begin
            ef = e + 10'sd1;
            fr = rm[23:1];
        end else begin
            ef = e;
            fr = rm[22:0];
        end
        if (ef >= 10'sd255)    return {s, 8'hFF, 23'd0};
        else if (ef <= 10'sd0) return {s, 31'd0};
        else                   return {s, ef[7:0], fr};
    endfunction

    logic [31:0] out_q, out_d;

    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic              sl, ss;
    logic [7:0]        el, es, d;
    logic [23:0]       ml, ms;
    logic [49:0]       sh;
    logic [26:0]       l_ext, s_ext, diff27, mnorm;
    logic [27:0]       sum28;
    logic [4:0]        lz;
    logic signed [9:0] enorm;

    always_comb begin
        nan_a  = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
        nan_b  = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
        inf_a  = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
        inf_b  = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
        zero_a = (A[30:23] == 8'h00);
        zero_b = (B[30:23] == 8'h00);

        // Order operands by magnitude; {exp, frac} compares as an integer.
        if (B[30:0] > A[30:0]) begin
            sl = B[31]; el = B[30:23]; ml = {1'b1, B[22:0]};
            ss = A[31]; es = A[30:23]; ms = {1'b1, A[22:0]};
        end else begin
            sl = A[31]; el = A[30:23]; ml = {1'b1, A[22:0]};
            ss = B[31]; es = B[30:23]; ms = {1'b1, B[22:0]};
        end
        d = el - es;

        // Align the smaller significand; everything below R collapses to sticky.
        sh = {ms, 26'd0} >> d;
        if (d > 8'd49) s_ext = 27'd1;
        else           s_ext = {sh[49:26], sh[25], sh[24], |sh[23:0]};
        l_ext = {ml, 3'b000};

        sum28  = {1'b0, l_ext} + {1'b0, s_ext};
        diff27 = l_ext - s_ext;
        lz     = lzc27(diff27);
        mnorm  = 27'd0;
        enorm  = 10'sd0;

        if (sl == ss) begin
            if (sum28[27]) begin
                mnorm = {sum28[27:2], sum28[1] | sum28[0]};
                enorm = $signed({2'b00, el}) + 10'sd1;
            end else begin
                mnorm = sum28[26:0];
                enorm = $signed({2'b00, el});
            end
        end else begin
            mnorm = diff27 << lz;
            enorm = $signed({2'b00, el}) - $signed({5'd0, lz});
        end

        if (nan_a || nan_b)                     out_d = QNAN;
        else if (inf_a && inf_b && (A[31] != B[31])) out_d = QNAN;
        else if (inf_a)                         out_d = A;
        else if (inf_b)                         out_d = B;
        else if (zero_a && zero_b)              out_d = {A[31] & B[31], 31'd0};
        else if (zero_a)                        out_d = B;
        else if (zero_b)                        out_d = A;
        else if ((sl != ss) && (diff27 == 27'd0)) out_d = 32'h00000000;
        else                                    out_d = round_pack(sl, enorm, mnorm);
    end

    always_ff @(posedge CLK) begin
        if (RST)     out_q <= 32'h00000000;
        else if (EN) out_q <= out_d;
    end

    assign OUT_Add = out_q;

endmodule

// File: tb/tb_floating_addition.sv
module tb_floating_addition;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] OUT_Add;

    int errors = 0;
    int checks = 0;

    floating_addition dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .A      (A),
        .B      (B),
        .OUT_Add(OUT_Add)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] expv);
        checks++;
        assert (OUT_Add === expv)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, OUT_Add, expv);
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic en,
                        input logic [31:0] a, input logic [31:0] b);
        RST = rst; EN = en; A = a; B = b;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b1; A = 32'h3F800000; B = 32'h3F800000;
        #2;

        step(1'b1, 1'b1, 32'h3F800000, 32'h40000000); check("reset_1", 32'h00000000);
        step(1'b1, 1'b1, 32'h41B26666, 32'hBF000000); check("reset_2", 32'h00000000);
        step(1'b0, 1'b1, 32'h41B26666, 32'hBF000000); check("first_22.3-0.5", 32'h41AE6666);

        step(1'b0, 1'b1, 32'h417CCCCD, 32'h3FA66666); check("rnd_15.8+1.3", 32'h4188CCCD);
        step(1'b0, 1'b1, 32'h3F28F5C2, 32'h3F028F5C); check("rnd_0.66+0.51", 32'h3F95C28F);

        step(1'b0, 1'b1, 32'hC0CCCCCC, 32'hBF000000); check("neg_add", 32'hC0DCCCCC);
        step(1'b0, 1'b1, 32'h40CCCCCC, 32'hBF000000); check("sub_ab", 32'h40BCCCCC);
        step(1'b0, 1'b1, 32'hBF000000, 32'h40CCCCCC); check("sub_ba", 32'h40BCCCCC);
        step(1'b0, 1'b1, 32'hBF800000, 32'h40000000); check("m1_plus_2", 32'h3F800000);
        step(1'b0, 1'b1, 32'h42600000, 32'h00000000); check("plus_zero", 32'h42600000);
        step(1'b0, 1'b1, 32'h80000000, 32'h80000000); check("negz_negz", 32'h80000000);
        step(1'b0, 1'b1, 32'h00000000, 32'h80000000); check("posz_negz", 32'h00000000);
        step(1'b0, 1'b1, 32'h00000001, 32'h3F800000); check("subnorm_as_zero", 32'h3F800000);

        step(1'b0, 1'b1, 32'hFF800000, 32'h404CCCCC); check("neg_inf", 32'hFF800000);
        step(1'b0, 1'b1, 32'h7F800000, 32'hFF800000); check("inf_minus_inf", 32'h7FC00000);
        step(1'b0, 1'b1, 32'h7FC00001, 32'h3F800000); check("nan_in", 32'h7FC00000);
        step(1'b0, 1'b1, 32'h3F800000, 32'hBF800000); check("cancel", 32'h00000000);
        step(1'b0, 1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF); check("overflow", 32'h7F800000);
        step(1'b0, 1'b1, 32'h00800000, 32'h80800001); check("underflow_flush", 32'h80000000);

        step(1'b0, 1'b1, 32'h3F800000, 32'h3F800000); check("load_1+1", 32'h40000000);
        step(1'b0, 1'b0, 32'h41B26666, 32'hBF000000); check("hold_1", 32'h40000000);
        step(1'b0, 1'b0, 32'hC0CCCCCC, 32'hBF000000); check("hold_2", 32'h40000000);
        step(1'b0, 1'b0, 32'h7F800000, 32'hFF800000); check("hold_3", 32'h40000000);
        step(1'b0, 1'b1, 32'hBF800000, 32'h40000000); check("reenable", 32'h3F800000);

        step(1'b1, 1'b1, 32'h41B26666, 32'hBF000000); check("mid_reset", 32'h00000000);
        step(1'b0, 1'b0, 32'h41B26666, 32'hBF000000); check("post_reset_en0", 32'h00000000);
        step(1'b0, 1'b1, 32'h41B26666, 32'hBF000000); check("post_reset_en1", 32'h41AE6666);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
